// File: rtl/tpu_dma_sched.sv
// Round-robin scheduler sharing the AXI burst master's read and write engines
// between on-chip requesters; each direction runs its own channel FSM.

module tpu_dma_sched_chan #(
   parameter int   N_REQ    = 3,
   parameter int   START_TO = 16,
   parameter logic DIR      = 1'b0
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_dir,
   input  logic [32*N_REQ-1:0]  req_addr,
   input  logic [32*N_REQ-1:0]  req_nburst,
   input  logic                 eng_idle,
   output logic [N_REQ-1:0]     req_ack,
   output logic [N_REQ-1:0]     req_done,
   output logic                 eng_start,
   output logic [31:0]          eng_addr,
   output logic [31:0]          eng_nburst,
   output logic                 busy,
   output logic                 err_to
);
   // state   | meaning
   // S_IDLE  | engine free, arbitrate among matching requesters
   // S_ISSUE | START driven, waiting for engine idle to drop
   // S_WAIT  | transfer running, waiting for engine idle to return
   // S_DONE  | pulse req_done for the granted requester
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(START_TO + 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     gnt_q, gnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       nburst_q, nburst_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              start_q, start_d;
   logic              err_q, err_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  done_q, done_d;

   logic [31:0]       addr_arr   [N_REQ];
   logic [31:0]       nburst_arr [N_REQ];
   logic [N_REQ-1:0]  match;
   logic              found;
   logic [IW-1:0]     pick_idx;
   logic [IW-1:0]     cand;
   int                j;

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign addr_arr[k]   = req_addr[32*k +: 32];
      assign nburst_arr[k] = req_nburst[32*k +: 32];
   end

   // First matching requester at or after the pointer, wrapping.
   always_comb begin
      match    = req_valid & (DIR ? req_dir : ~req_dir);
      found    = 1'b0;
      pick_idx = '0;
      cand     = '0;
      j        = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N_REQ) j = j - N_REQ;
         cand = IW'(j);
         if (!found && match[cand]) begin
            found    = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      addr_d   = addr_q;
      nburst_d = nburst_q;
      timer_d  = timer_q;
      start_d  = start_q;
      err_d    = err_q;
      ack_d    = '0;
      done_d   = '0;
      case (state_q)
         S_IDLE: begin
            start_d = 1'b0;
            if (eng_idle && found) begin
               ack_d[pick_idx] = 1'b1;
               gnt_d           = pick_idx;
               ptr_d           = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
               addr_d          = addr_arr[pick_idx];
               nburst_d        = nburst_arr[pick_idx];
               timer_d         = TW'(START_TO);
               state_d         = (nburst_arr[pick_idx] == 32'd0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!eng_idle) begin
               start_d = 1'b0;
               state_d = S_WAIT;
            end else if (start_q && timer_q == TW'(1)) begin
               // engine never acknowledged the start: abort and release the requester
               start_d        = 1'b0;
               err_d          = 1'b1;
               done_d[gnt_q]  = 1'b1;
               state_d        = S_DONE;
            end else begin
               start_d = 1'b1;
               if (start_q) timer_d = timer_q - 1'b1;
            end
         end
         S_WAIT: begin
            start_d = 1'b0;
            if (eng_idle) begin
               done_d[gnt_q] = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            start_d = 1'b0;
            // arriving from S_WAIT/S_ISSUE the pulse is already out; zero-burst grants raise it here
            if (done_q != '0) state_d = S_IDLE;
            else              done_d[gnt_q] = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         addr_q   <= '0;
         nburst_q <= '0;
         timer_q  <= '0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
         ack_q    <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         nburst_q <= nburst_d;
         timer_q  <= timer_d;
         start_q  <= start_d;
         err_q    <= err_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
      end
   end

   assign req_ack    = ack_q;
   assign req_done   = done_q;
   assign eng_start  = start_q;
   assign eng_addr   = addr_q;
   assign eng_nburst = nburst_q;
   assign busy       = (state_q != S_IDLE);
   assign err_to     = err_q;
endmodule

module tpu_dma_sched #(
   parameter int N_REQ    = 3,
   parameter int START_TO = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_dir,
   input  logic [32*N_REQ-1:0]  req_addr,
   input  logic [32*N_REQ-1:0]  req_nburst,
   output logic [N_REQ-1:0]     req_ack,
   output logic [N_REQ-1:0]     req_done,
   output logic                 RSTART_REG,
   output logic [31:0]          RADDR_REG,
   output logic [31:0]          RNBURST_REG,
   input  logic                 RIDLE_REG,
   output logic                 WSTART_REG,
   output logic [31:0]          WADDR_REG,
   output logic [31:0]          WNBURST_REG,
   input  logic                 WIDLE_REG,
   output logic                 rd_busy,
   output logic                 wr_busy,
   output logic [1:0]           err_to
);
   logic [N_REQ-1:0] rd_ack, rd_done, wr_ack, wr_done;
   logic             rd_err, wr_err;

   tpu_dma_sched_chan #(.N_REQ(N_REQ), .START_TO(START_TO), .DIR(1'b0)) u_rd (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .req_valid  (req_valid),
      .req_dir    (req_dir),
      .req_addr   (req_addr),
      .req_nburst (req_nburst),
      .eng_idle   (RIDLE_REG),
      .req_ack    (rd_ack),
      .req_done   (rd_done),
      .eng_start  (RSTART_REG),
      .eng_addr   (RADDR_REG),
      .eng_nburst (RNBURST_REG),
      .busy       (rd_busy),
      .err_to     (rd_err)
   );

   tpu_dma_sched_chan #(.N_REQ(N_REQ), .START_TO(START_TO), .DIR(1'b1)) u_wr (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .req_valid  (req_valid),
      .req_dir    (req_dir),
      .req_addr   (req_addr),
      .req_nburst (req_nburst),
      .eng_idle   (WIDLE_REG),
      .req_ack    (wr_ack),
      .req_done   (wr_done),
      .eng_start  (WSTART_REG),
      .eng_addr   (WADDR_REG),
      .eng_nburst (WNBURST_REG),
      .busy       (wr_busy),
      .err_to     (wr_err)
   );

   // a requester has one dir bit, so the two channels never pulse the same bit
   assign req_ack  = rd_ack | wr_ack;
   assign req_done = rd_done | wr_done;
   assign err_to   = {wr_err, rd_err};
endmodule

// File: tb/tb_tpu_dma_sched.sv
// Scoreboard bench for tpu_dma_sched: directed requests push expected events,
// a negedge monitor pops and compares ack/start/stop/done with cycle stamps.

module tb_tpu_dma_sched;
   localparam int N_REQ    = 3;
   localparam int START_TO = 16;
   localparam int EV_ACK   = 0;
   localparam int EV_START = 1;
   localparam int EV_STOP  = 2;
   localparam int EV_DONE  = 3;

   typedef struct {
      int          kind;
      int          idx;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] nb;
   } ev_t;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_dir;
   logic [32*N_REQ-1:0] req_addr;
   logic [32*N_REQ-1:0] req_nburst;
   logic [N_REQ-1:0]    req_ack, req_done;
   logic                RSTART_REG, WSTART_REG;
   logic [31:0]         RADDR_REG, RNBURST_REG, WADDR_REG, WNBURST_REG;
   logic                RIDLE_REG, WIDLE_REG;
   logic                rd_busy, wr_busy;
   logic [1:0]          err_to;
   logic [1:0]          eng_idle = 2'b11;
   logic [1:0]          st_now;

   int eng_drop [2] = '{2, 2};
   int eng_len  [2] = '{20, 20};
   bit eng_hang [2] = '{0, 0};
   int issued [N_REQ] = '{default: 0};
   int acked  [N_REQ] = '{default: 0};
   int dir_of [N_REQ] = '{default: 0};
   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   ev_t q_r[$];
   ev_t q_w[$];

   tpu_dma_sched #(.N_REQ(N_REQ), .START_TO(START_TO)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .req_valid   (req_valid),
      .req_dir     (req_dir),
      .req_addr    (req_addr),
      .req_nburst  (req_nburst),
      .req_ack     (req_ack),
      .req_done    (req_done),
      .RSTART_REG  (RSTART_REG),
      .RADDR_REG   (RADDR_REG),
      .RNBURST_REG (RNBURST_REG),
      .RIDLE_REG   (RIDLE_REG),
      .WSTART_REG  (WSTART_REG),
      .WADDR_REG   (WADDR_REG),
      .WNBURST_REG (WNBURST_REG),
      .WIDLE_REG   (WIDLE_REG),
      .rd_busy     (rd_busy),
      .wr_busy     (wr_busy),
      .err_to      (err_to)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   assign RIDLE_REG = eng_idle[0];
   assign WIDLE_REG = eng_idle[1];
   assign st_now    = {WSTART_REG, RSTART_REG};

   always_comb begin
      req_valid = '0;
      for (int k = 0; k < N_REQ; k++) req_valid[k] = (issued[k] != acked[k]);
   end

   function automatic string kname(input int kind);
      case (kind)
         EV_ACK:   return "ack";
         EV_START: return "start";
         EV_STOP:  return "stop";
         default:  return "done";
      endcase
   endfunction

   task automatic push(input int ch, input int kind, input int idx, input int c,
                       input logic [31:0] addr, input logic [31:0] nb);
      ev_t e;
      e.kind = kind; e.idx = idx; e.cyc = c; e.addr = addr; e.nb = nb;
      if (ch == 0) q_r.push_back(e);
      else         q_w.push_back(e);
   endtask

   // full transfer with ack at cycle a and engine drop/len d/l
   task automatic push_xfer(input int ch, input int k, input int a, input logic [31:0] addr,
                            input logic [31:0] nb, input int d, input int l);
      push(ch, EV_ACK,   k,  a,             '0,   '0);
      push(ch, EV_START, -1, a + 1,         addr, nb);
      push(ch, EV_STOP,  -1, a + d + 2,     '0,   '0);
      push(ch, EV_DONE,  k,  a + d + l + 2, '0,   '0);
   endtask

   task automatic got(input int ch, input int kind, input int idx);
      ev_t         e;
      logic [31:0] a_addr, a_nb;
      a_addr = (ch == 0) ? RADDR_REG : WADDR_REG;
      a_nb   = (ch == 0) ? RNBURST_REG : WNBURST_REG;
      n_cmp++;
      if ((ch == 0 && q_r.size() == 0) || (ch == 1 && q_w.size() == 0)) begin
         n_err++;
         $display("FAIL ev_ch%0d: got %s idx %0d at cycle %0d, required no event",
                  ch, kname(kind), idx, cyc);
         return;
      end
      e = (ch == 0) ? q_r.pop_front() : q_w.pop_front();
      if (e.kind != kind || e.idx != idx || e.cyc != cyc ||
          (kind == EV_START && (a_addr !== e.addr || a_nb !== e.nb))) begin
         n_err++;
         $display("FAIL ev_ch%0d: got %s idx %0d cyc %0d addr %h nb %0d, required %s idx %0d cyc %0d addr %h nb %0d",
                  ch, kname(kind), idx, cyc, a_addr, a_nb, kname(e.kind), e.idx, e.cyc, e.addr, e.nb);
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic issue(input int k, input logic dir, input logic [31:0] addr,
                        input logic [31:0] nb, input int count);
      req_dir[k]             = dir;
      req_addr[32*k +: 32]   = addr;
      req_nburst[32*k +: 32] = nb;
      dir_of[k]              = int'(dir);
      issued[k]              = issued[k] + count;
   endtask

   // requester agents: count acks, which retires one pending request each
   initial begin
      forever begin
         @(posedge aclk); #1;
         for (int k = 0; k < N_REQ; k++)
            if (req_ack[k] === 1'b1) acked[k] = acked[k] + 1;
      end
   end

   // engine model for both channels
   initial begin
      int ph [2];
      int cnt [2];
      ph = '{0, 0}; cnt = '{0, 0};
      forever begin
         @(posedge aclk); #1;
         for (int c = 0; c < 2; c++) begin
            if (!aresetn) begin
               eng_idle[c] = 1'b1; ph[c] = 0;
            end else begin
               case (ph[c])
                  0: if (st_now[c] === 1'b1 && !eng_hang[c]) begin ph[c] = 1; cnt[c] = eng_drop[c]; end
                  1: begin
                     cnt[c] = cnt[c] - 1;
                     if (cnt[c] == 0) begin eng_idle[c] = 1'b0; ph[c] = 2; cnt[c] = eng_len[c]; end
                  end
                  default: begin
                     cnt[c] = cnt[c] - 1;
                     if (cnt[c] == 0) begin eng_idle[c] = 1'b1; ph[c] = 0; end
                  end
               endcase
            end
         end
      end
   end

   // monitor
   initial begin
      logic [1:0] prev;
      prev = 2'b00;
      forever begin
         @(negedge aclk);
         for (int c = 0; c < 2; c++) begin
            if (st_now[c] === 1'b1 && prev[c] == 1'b0) got(c, EV_START, -1);
            if (st_now[c] === 1'b0 && prev[c] == 1'b1) got(c, EV_STOP, -1);
            prev[c] = (st_now[c] === 1'b1);
         end
         for (int k = 0; k < N_REQ; k++) begin
            if (req_ack[k] === 1'b1)  got(dir_of[k], EV_ACK, k);
            if (req_done[k] === 1'b1) got(dir_of[k], EV_DONE, k);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, required finish");
      $fatal(1);
   end

   initial begin
      int t;
      req_dir = '0; req_addr = '0; req_nburst = '0;
      aresetn = 1'b0;
      tick(3);
      check("rst_ack_done", {req_ack, req_done}, '0);
      check("rst_start",    {RSTART_REG, WSTART_REG, rd_busy, wr_busy, err_to}, '0);
      check("rst_raddr",    {RADDR_REG, RNBURST_REG}, '0);
      check("rst_waddr",    {WADDR_REG, WNBURST_REG}, '0);
      aresetn = 1'b1;
      tick(2);

      // round-robin reads: 0,1,2,0 with 8-cycle spacing (drop 1, len 3)
      eng_drop = '{1, 1}; eng_len = '{3, 3};
      t = cyc;
      issue(0, 1'b0, 32'h2000_0000, 32'd1, 2);
      issue(1, 1'b0, 32'h2000_0100, 32'd2, 1);
      issue(2, 1'b0, 32'h2000_0200, 32'd3, 1);
      push_xfer(0, 0, t + 1,  32'h2000_0000, 32'd1, 1, 3);
      push_xfer(0, 1, t + 9,  32'h2000_0100, 32'd2, 1, 3);
      push_xfer(0, 2, t + 17, 32'h2000_0200, 32'd3, 1, 3);
      push_xfer(0, 0, t + 25, 32'h2000_0000, 32'd1, 1, 3);
      tick(5);
      check("rr_busy", {rd_busy, wr_busy}, 2'b10);
      tick(30);

      // single read
      eng_drop = '{2, 2}; eng_len = '{20, 20};
      t = cyc;
      issue(0, 1'b0, 32'h1000_0000, 32'd4, 1);
      push_xfer(0, 0, t + 1, 32'h1000_0000, 32'd4, 2, 20);
      tick(2);
      check("sr_start_t2", {RSTART_REG, RADDR_REG, RNBURST_REG}, {1'b1, 32'h1000_0000, 32'd4});
      tick(2);
      check("sr_start_t4", RSTART_REG, 1'b1);
      tick(1);
      check("sr_start_t5", RSTART_REG, 1'b0);
      tick(25);

      // concurrent read (req 0) and write (req 2)
      eng_drop = '{2, 1}; eng_len = '{20, 5};
      t = cyc;
      issue(0, 1'b0, 32'h3000_0000, 32'd8, 1);
      issue(2, 1'b1, 32'h4000_0000, 32'd2, 1);
      push_xfer(0, 0, t + 1, 32'h3000_0000, 32'd8, 2, 20);
      push_xfer(1, 2, t + 1, 32'h4000_0000, 32'd2, 1, 5);
      tick(2);
      check("cc_both_start", {RSTART_REG, WSTART_REG}, 2'b11);
      tick(28);

      // zero-burst write from req 1
      t = cyc;
      issue(1, 1'b1, 32'h5555_0000, 32'd0, 1);
      push(1, EV_ACK,  1, t + 1, '0, '0);
      push(1, EV_DONE, 1, t + 2, '0, '0);
      tick(1);
      check("nb0_latch", {WADDR_REG, WNBURST_REG, wr_busy}, {32'h5555_0000, 32'd0, 1'b1});
      tick(5);

      // start timeout on the read channel
      eng_hang[0] = 1'b1;
      t = cyc;
      issue(2, 1'b0, 32'h6000_0000, 32'd3, 1);
      push(0, EV_ACK,   2,  t + 1,            '0,            '0);
      push(0, EV_START, -1, t + 2,            32'h6000_0000, 32'd3);
      push(0, EV_STOP,  -1, t + 2 + START_TO, '0,            '0);
      push(0, EV_DONE,  2,  t + 2 + START_TO, '0,            '0);
      tick(START_TO + 1);
      check("to_last_start", {RSTART_REG, err_to}, {1'b1, 2'b00});
      tick(1);
      check("to_abort", {RSTART_REG, err_to}, {1'b0, 2'b01});
      tick(2);
      check("to_idle", rd_busy, 1'b0);
      eng_hang[0] = 1'b0;
      eng_drop = '{1, 1}; eng_len = '{2, 2};
      t = cyc;
      issue(1, 1'b0, 32'h6100_0000, 32'd1, 1);
      push_xfer(0, 1, t + 1, 32'h6100_0000, 32'd1, 1, 2);
      tick(12);
      check("to_sticky", err_to, 2'b01);

      // reset during S_WAIT
      eng_drop = '{2, 2}; eng_len = '{20, 20};
      t = cyc;
      issue(1, 1'b0, 32'h7000_0000, 32'd5, 1);
      push(0, EV_ACK,   1,  t + 1, '0,            '0);
      push(0, EV_START, -1, t + 2, 32'h7000_0000, 32'd5);
      push(0, EV_STOP,  -1, t + 5, '0,            '0);
      tick(8);
      check("mr_in_wait", {rd_busy, RSTART_REG}, 2'b10);
      aresetn = 1'b0;
      tick(1);
      check("mr_outs", {req_ack, req_done, RSTART_REG, WSTART_REG, rd_busy, wr_busy, err_to}, '0);
      check("mr_regs", {RADDR_REG, RNBURST_REG, WADDR_REG, WNBURST_REG}, '0);
      tick(2);
      aresetn = 1'b1;
      tick(25);

      // after reset requester 0 is first again even though 2 asks too
      eng_drop = '{1, 1}; eng_len = '{2, 2};
      t = cyc;
      issue(2, 1'b0, 32'h7100_0000, 32'd1, 1);
      issue(0, 1'b0, 32'h7200_0000, 32'd2, 1);
      push_xfer(0, 0, t + 1, 32'h7200_0000, 32'd2, 1, 2);
      push_xfer(0, 2, t + 8, 32'h7100_0000, 32'd1, 1, 2);
      tick(20);

      check("left_rd", q_r.size(), 0);
      check("left_wr", q_w.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/tpu_dma_sched.md
# tpu_dma_sched

Round-robin scheduler that shares the single AXI burst master's read and write engines between several on-chip requesters (weight loader, feature-map loader, result writer). It sits between the requesters and the master's RSTART/RADDR/RNBURST/RIDLE and WSTART/WADDR/WNBURST/WIDLE register interface, replacing direct register-driven starts. The read and write channels are scheduled independently, so one read and one write can be in flight at once.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- START_TO, 16, cycles to wait for engine idle to drop after start before aborting

Ports:
- Reset: aresetn, synchronous, active-low. Clock: aclk.
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- req_valid  in  N_REQ  request pending, held until req_ack
- req_dir  in  N_REQ  0 = read (DDR→fabric), 1 = write
- req_addr  in  32*N_REQ  byte start address, requester k at [32k+:32]
- req_nburst  in  32*N_REQ  number of bursts
- req_ack  out  N_REQ  one-cycle grant pulse, request latched
- req_done  out  N_REQ  one-cycle completion pulse
- RSTART_REG / WSTART_REG  out  1  engine start
- RADDR_REG / WADDR_REG  out  32  engine address
- RNBURST_REG / WNBURST_REG  out  32  engine burst count
- RIDLE_REG / WIDLE_REG  in  1  engine idle (1 = idle)
- rd_busy / wr_busy  out  1  channel not in S_IDLE
- err_to  out  2  sticky start-timeout flags {write, read}

## Operation
- Two identical channel FSMs: read channel serves requesters with req_dir=0, write channel those with req_dir=1. Descriptions below use START/ADDR/NBURST/IDLE for the channel's engine signals.
- States: S_IDLE, S_ISSUE, S_WAIT, S_DONE.
- S_IDLE: if IDLE=1 and any requester k has req_valid[k]=1 with matching dir, pick k by round-robin. Next cycle: req_ack[k]=1 for one cycle; ADDR and NBURST are latched from requester k; the grant index is stored. The next state is S_ISSUE, or S_DONE if nburst=0.
- S_ISSUE: START=1. When IDLE=0, go to S_WAIT and drop START. If START_TO cycles pass with IDLE still 1, set err_to bit, drop START, go to S_DONE (abort).
- S_WAIT: START=0. When IDLE=1, go to S_DONE.
- S_DONE: req_done[k]=1 for one cycle, then go to S_IDLE.
- Round-robin: a per-channel pointer gives priority to the requester after the last one granted on that channel, wrapping N_REQ-1→0. After reset, requester 0 has highest priority.
- Requester contract:
  - Deassert req_valid the cycle after it sees req_ack.
  - Inputs need not be held after the ack.
  - A requester cannot be granted on both channels at once because it has one dir bit.
- ADDR/NBURST hold their last latched value until the next grant.
- err_to is cleared only by reset.

## Timing
- Reset values: all outputs 0, states S_IDLE, pointers 0, err_to=0.
- Reset asserted mid-transfer drops START immediately (registered, next edge). No req_done is issued for the aborted transfer.
- Request to ack: 1 cycle (valid seen at cycle t, ack at t+1; START first high at t+2).
- START stays high from entry into S_ISSUE until the cycle after IDLE=0 is sampled.
- Done: req_done is high 1 cycle after IDLE returns to 1 is sampled in S_WAIT.
- Minimum back-to-back spacing on one channel: next ack no earlier than 1 cycle after req_done.
- nburst=0: ack at t+1, done at t+2; START never asserted.
- Simultaneous read and write grants in the same cycle are allowed and independent.
- A valid arriving while the channel is busy waits; no queuing beyond req_valid.

## Test plan
- Single read: req 0 with dir=0, addr=0x1000_0000, nburst=4; engine model drops IDLE 2 cycles after START and raises it 20 cycles later. Expect: ack at t+1; RADDR_REG=0x1000_0000 and RNBURST_REG=4 while START is high; START is high exactly until IDLE drops; req_done[0] 1 cycle after IDLE rises.
- Round-robin: requesters 0, 1, 2 all request reads continuously. Expect grant order 0, 1, 2, 0. Write channel stays idle.
- Concurrent channels: req 0 reads and req 2 writes in the same cycle. Expect both acks in the same cycle and RSTART/WSTART high together. Each done follows its own IDLE.
- nburst=0 write from req 1: ack, then done on the next cycle. WSTART_REG stays 0.
- Timeout: IDLE is held at 1 forever after START. Expect START high for START_TO cycles, err_to[0]=1, req_done pulsed, and the channel back in S_IDLE accepting the next request.
- Reset mid-transfer: assert aresetn=0 during S_WAIT. Expect all outputs 0 on the next edge and no req_done. A new request after reset is served with requester 0 at highest priority.
